// File: rtl/narrow_pkg.sv
// narrow_pkg: shared widths and range limits for the 32->16 narrowing unit.
// The limits are sized to the default output width; narrow_core uses them directly.
package narrow_pkg;

    localparam int unsigned IN_W_DEF  = 32;
    localparam int unsigned OUT_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [OUT_W_DEF-1:0] SMAX = 16'h7FFF;
    localparam logic [OUT_W_DEF-1:0] SMIN = 16'h8000;
    localparam logic [OUT_W_DEF-1:0] UMAX = 16'hFFFF;

endpackage

// File: rtl/narrow_sat_if.sv
// narrow_sat_if: input and output valid/ready handshakes of the narrowing stage.
//   in_valid/in_ready/a/sext   : word from the datapath result bus
//   out_valid/out_ready/b/ovf  : narrowed result towards the 16-bit consumer
// Modports: master = producer/consumer side (testbench), slave = narrow_sat.
interface narrow_sat_if
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  a;
    logic             sext;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] b;
    logic             ovf;

    modport master (
        output in_valid, a, sext, out_ready,
        input  in_ready, out_valid, b, ovf
    );

    modport slave (
        input  in_valid, a, sext, out_ready,
        output in_ready, out_valid, b, ovf
    );

endinterface

// File: rtl/narrow_core.sv
// narrow_core: combinational range check and saturate/wrap selection.
//   a        : input word
//   sext     : 1 = signed interpretation, 0 = unsigned
//   b_next   : narrowed value
//   ovf_next : a did not fit in OUT_W bits under the chosen interpretation
module narrow_core
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter bit          SAT   = 1'b1
) (
    input  logic [IN_W-1:0]  a,
    input  logic             sext,
    output logic [OUT_W-1:0] b_next,
    output logic             ovf_next
);

    localparam int unsigned HI_W = IN_W - OUT_W;

    // Signed fits iff the discarded bits plus the new sign bit are all copies of one value.
    logic [HI_W:0]   s_hi;
    logic [HI_W-1:0] u_hi;
    logic            s_fit;
    logic            u_fit;

    assign s_hi  = a[IN_W-1:OUT_W-1];
    assign u_hi  = a[IN_W-1:OUT_W];
    assign s_fit = (s_hi == '0) || (s_hi == '1);
    assign u_fit = (u_hi == '0);

    always_comb begin
        b_next   = a[OUT_W-1:0];
        ovf_next = 1'b0;
        if (sext) begin
            if (!s_fit) begin
                ovf_next = 1'b1;
                if (SAT) begin
                    b_next = a[IN_W-1] ? SMIN : SMAX;
                end
            end
        end else begin
            if (!u_fit) begin
                ovf_next = 1'b1;
                if (SAT) begin
                    b_next = UMAX;
                end
            end
        end
    end

endmodule

// File: rtl/narrow_sat.sv
// narrow_sat: registered 32->16 narrowing stage with overflow statistics.
//   clk, rst   : clock and synchronous active-high reset
//   bus        : in/out valid-ready handshakes (slave side of narrow_sat_if)
//   clr        : clears ovf_sticky and ovf_count
//   ovf_sticky : set by any accepted overflow
//   ovf_count  : accepted overflows, saturating at all-ones
module narrow_sat
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter bit          SAT   = 1'b1,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    narrow_sat_if.slave      bus,
    input  logic             clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    logic [OUT_W-1:0] b_next;
    logic             ovf_next;
    logic             accept;

    logic             out_valid_q;
    logic [OUT_W-1:0] b_q;
    logic             ovf_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    narrow_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SAT   (SAT)
    ) u_core (
        .a        (bus.a),
        .sext     (bus.sext),
        .b_next   (b_next),
        .ovf_next (ovf_next)
    );

    // Single-entry register: a drain and a fill may happen in the same cycle.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.b         = b_q;
    assign bus.ovf       = ovf_q;
    assign ovf_sticky    = sticky_q;
    assign ovf_count     = count_q;

    // Clear first, then count the overflow of the word accepted this cycle.
    always_comb begin
        sticky_d = clr ? 1'b0 : sticky_q;
        count_d  = clr ? '0 : count_q;
        if (accept && ovf_next) begin
            sticky_d = 1'b1;
            if (count_d != '1) begin
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            b_q         <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                b_q         <= b_next;
                ovf_q       <= ovf_next;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_narrow_sat.sv
module tb_narrow_sat;
    import narrow_pkg::*;

    localparam bit SAT = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       ovf_sticky;
    logic [7:0] ovf_count;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb[$];  // {b, ovf} expected in delivery order

    narrow_sat_if bus ();

    narrow_sat #(
        .IN_W  (32),
        .OUT_W (16),
        .SAT   (SAT),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr        (clr),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next edge when out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got b=%h ovf=%b expected none", bus.b, bus.ovf);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if ({bus.b, bus.ovf} !== e) begin
                    errors++;
                    $display("FAIL output: got b=%h ovf=%b expected b=%h ovf=%b",
                             bus.b, bus.ovf, e[16:1], e[0]);
                end
            end
        end
    end

    // Present a word and wait (bounded) for its acceptance; returns at posedge+1.
    task automatic send(input logic s, input logic [31:0] a, input logic [15:0] eb,
                        input logic eo);
        logic acc;
        int   n;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.sext     = s;
        acc          = 1'b0;
        n            = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) sb.push_back({eb, eo});
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h0;
        bus.sext      = 1'b1;
        bus.out_ready = 1'b1;

        // 1: reset with in_valid held high
        idle(2);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_b", 32'(bus.b), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_count", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        send(1'b1, 32'h0000_0000, 16'h0000, 1'b0);
        check("first_out_valid", 32'(bus.out_valid), 32'd1);

        // 2: range checks
        send(1'b1, 32'hFFFF_8000, 16'h8000, 1'b0);
        send(1'b0, 32'h0000_8000, 16'h8000, 1'b0);
        send(1'b1, 32'h0000_8000, SAT ? 16'h7FFF : 16'h8000, 1'b1);
        send(1'b0, 32'hFFFF_FFFF, 16'hFFFF, 1'b1);
        send(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
        idle(2);
        check("stream_count", 32'(ovf_count), 32'd2);
        check("stream_sticky", 32'(ovf_sticky), 32'd1);
        check("drained", 32'(bus.out_valid), 32'd0);

        // 3: backpressure then pass-through
        bus.out_ready = 1'b0;
        send(1'b0, 32'h0000_1234, 16'h1234, 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_5678;
        bus.sext     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_b", 32'(bus.b), 32'h1234);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            idle(1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("pass_in_ready", 32'(bus.in_ready), 32'd1);
        send(1'b0, 32'h0000_5678, 16'h5678, 1'b0);
        check("pass_out_valid", 32'(bus.out_valid), 32'd1);
        check("pass_b", 32'(bus.b), 32'h5678);
        idle(2);

        // 4: counter saturation then clr alone
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 32'h7FFF_FFFF, SAT ? 16'h7FFF : 16'hFFFF, 1'b1);
        end
        idle(2);
        check("sat_count", 32'(ovf_count), 32'd255);
        check("sat_sticky", 32'(ovf_sticky), 32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("clr_count", 32'(ovf_count), 32'd0);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);

        // 5: clr together with an accepted overflow
        clr = 1'b1;
        send(1'b1, 32'h8000_0000, SAT ? 16'h8000 : 16'h0000, 1'b1);
        clr = 1'b0;
        check("clrovf_count", 32'(ovf_count), 32'd1);
        check("clrovf_sticky", 32'(ovf_sticky), 32'd1);
        idle(2);

        // 6: reset while a result is stalled
        send(1'b1, 32'h8000_0000, SAT ? 16'h8000 : 16'h0000, 1'b1);
        send(1'b1, 32'h8000_0000, SAT ? 16'h8000 : 16'h0000, 1'b1);
        idle(2);
        bus.out_ready = 1'b0;
        send(1'b0, 32'h0000_0042, 16'h0042, 1'b0);
        check("pre_rst_count", 32'(ovf_count), 32'd3);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb.delete();  // the stalled word must never appear
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_count", 32'(ovf_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/narrow_sat.md
Name: narrow_sat

Overview:
- Inverse of the 16->32 extension unit: narrows a 32-bit word to 16 bits.
- Interprets the word as signed (sext=1) or unsigned (sext=0).
- Detects out-of-range values and either saturates or wraps the result.
- Registered valid/ready stage placed between the datapath result bus and 16-bit consumers; keeps sticky and counted overflow statistics.

Parameters:
IN_W, 32, input word width
OUT_W, 16, output word width (OUT_W < IN_W)
SAT, 1, 1 = saturate on overflow; 0 = wrap (truncate)
CNT_W, 8, width of the overflow event counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word present
in_ready  out  1  block can accept the word this cycle
a  in  IN_W  input word
sext  in  1  1 = signed interpretation, 0 = unsigned; sampled with a
out_valid  out  1  b/ovf hold a result
out_ready  in  1  consumer accepts the result this cycle
b  out  OUT_W  narrowed result
ovf  out  1  the result in b was out of range
ovf_sticky  out  1  set by any accepted overflow; cleared by clr or rst
ovf_count  out  CNT_W  number of accepted overflows, saturating at all-ones
clr  in  1  clears ovf_sticky and ovf_count

Behaviour:
- Reset values: out_valid=0, b=0, ovf=0, ovf_sticky=0, ovf_count=0.
- Reset applies regardless of in-flight data; a held result is discarded.
- Accept: accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, with pass-through on simultaneous drain and fill.
- Latency: 1 cycle. A word accepted at edge N appears with out_valid=1 after edge N.
- Hold: while out_valid && !out_ready, b and ovf are stable and in_ready=0.
- Drain: out_valid clears at a cycle where out_ready=1 and no new word is accepted.
- Signed range check (sext=1): in range iff a[IN_W-1:OUT_W-1] are all equal.
  - In range: b = a[OUT_W-1:0], ovf=0.
  - Out of range with SAT=1: b = 16'h7FFF if a[IN_W-1]=0, else 16'h8000.
  - Out of range with SAT=0: b = a[OUT_W-1:0].
  - ovf=1 in both out-of-range cases.
- Unsigned range check (sext=0): in range iff a[IN_W-1:OUT_W]==0.
  - Out of range with SAT=1: b = 16'hFFFF.
  - Out of range with SAT=0: b = a[OUT_W-1:0].
  - ovf=1 in both out-of-range cases.
- Statistics are updated only on accept with overflow (not at output drain):
  - ovf_sticky <= 1.
  - ovf_count <= ovf_count+1, holding at 2^CNT_W-1 (no wrap).
- clr alone: ovf_sticky <= 0, ovf_count <= 0.
- clr in the same cycle as an accepted overflow: the clear applies first, then the event is counted. Result: ovf_sticky=1, ovf_count=1.
- clr and rst do not affect each other's priority; rst dominates everything.
- No state machine beyond the single-entry output register, which has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain+accept or on stall.
  - FULL -> EMPTY on drain without accept.
- in_valid may drop without acceptance. No X-propagation requirement on a/sext when in_valid=0.

Decomposition:
- Package narrow_pkg holds:
  - Default widths (IN_W, OUT_W, CNT_W).
  - Signed limits SMAX=16'h7FFF and SMIN=16'h8000.
  - Unsigned limit UMAX=16'hFFFF.
- One combinational sub-module, narrow_core (a, sext -> b_next, ovf_next), holds the range check and saturate/wrap selection.
- narrow_sat wraps narrow_core with the handshake register and the statistics.

Test Plan:
1. rst=1 for 2 cycles with in_valid=1 -> out_valid=0, b=0, ovf_sticky=0, ovf_count=0. Release rst; a=32'h00000000, sext=1 -> next cycle out_valid=1, b=16'h0000, ovf=0.
2. With out_ready=1, stream (sext,a) = (1,FFFF8000), (0,00008000), (1,00008000), (0,FFFFFFFF), (1,FFFFFFFF). Required b/ovf in order: 8000/0, 8000/0, 7FFF/1, FFFF/1, FFFF/0. Final ovf_count=2, ovf_sticky=1. The SAT=0 build gives 8000/1 for the third word and otherwise matches.
3. Backpressure: accept a=32'h00001234, then hold out_ready=0 for 5 cycles with in_valid=1, a=32'h00005678. b stays 16'h1234 and in_ready=0 throughout. Raise out_ready -> 16'h5678 is accepted that same cycle (pass-through) and out_valid stays 1.
4. Counter saturation: 300 consecutive overflows with a=32'h7FFFFFFF, sext=1 (CNT_W=8) -> ovf_count=255 and holds. Then pulse clr alone -> ovf_count=0, ovf_sticky=0.
5. clr asserted in the same cycle an overflow word (a=32'h80000000, sext=1) is accepted -> b=16'h8000, ovf=1, ovf_sticky=1, ovf_count=1.
6. Reset mid-stall: out_valid=1, out_ready=0, ovf_count=3. Assert rst for 1 cycle -> out_valid=0, ovf_count=0, in_ready=1. The stalled word is never delivered.
